usb_tx: RTL and testbench

USB full-speed transmitter, the TX counterpart of the endpoint's receive path. It accepts a packet command from the protocol controller and, for DATA0 packets, pulls payload bytes from the TX data buffer. It serialises SYNC, PID, payload and CRC16 with bit stuffing and NRZI encoding, then drives the EOP onto d_plus/d_minus.

---
 rtl/usb_tx.sv | 233 +++++++++++++++++++++++
 tb/tb_usb_tx.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx.sv
// usb_tx: USB full-speed transmitter. Serialises SYNC, PID, payload and CRC16 with bit stuffing and NRZI, then drives EOP.
// Define USB_TX_BYTE_CNT_EN to add the tx_byte_count output (payload bytes popped in the current/last packet).
module usb_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_transfer_active,
    output logic       tx_error,
`ifdef USB_TX_BYTE_CNT_EN
    output logic [6:0] tx_byte_count,
`endif
    output logic [2:0] fsm_state
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [7:0] MAX_B = 8'(MAX_BYTES);
    localparam logic [7:0] SYNC_BYTE = 8'h80;
    localparam logic [7:0] PID_DATA0 = 8'hC3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SYNC    = 3'd1,
        S_PID     = 3'd2,
        S_DATA    = 3'd3,
        S_CRC     = 3'd4,
        S_EOP_SE0 = 3'd5,
        S_EOP_J   = 3'd6
    } state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [4:0]    bit_idx, bit_idx_n;
    logic [2:0]    ones_cnt, ones_n;
    logic [7:0]    sreg, sreg_n;
    logic [15:0]   crc, crc_n;
    logic [7:0]    pid, pid_n;
    logic [6:0]    byte_cnt, byte_cnt_n;
    logic          dp_n, dm_n, active_n, err_n;

    logic          bit_end;
    logic          tx_en, tx_bit, stuff, crc_en, to_eop, next_byte, field_bit;
    logic [4:0]    field_len;
    logic [15:0]   crc_inv;

    assign bit_end   = (timer == TIMER_LAST);
    assign field_len = (state == S_CRC) ? 5'd16 : 5'd8;
    assign crc_inv   = ~crc;
    assign fsm_state = state;
`ifdef USB_TX_BYTE_CNT_EN
    assign tx_byte_count = byte_cnt;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state              <= S_IDLE;
            timer              <= '0;
            bit_idx            <= '0;
            ones_cnt           <= '0;
            sreg               <= '0;
            crc                <= 16'hFFFF;
            pid                <= '0;
            byte_cnt           <= '0;
            d_plus             <= 1'b1;
            d_minus            <= 1'b0;
            tx_transfer_active <= 1'b0;
            tx_error           <= 1'b0;
        end else begin
            state              <= state_n;
            timer              <= timer_n;
            bit_idx            <= bit_idx_n;
            ones_cnt           <= ones_n;
            sreg               <= sreg_n;
            crc                <= crc_n;
            pid                <= pid_n;
            byte_cnt           <= byte_cnt_n;
            d_plus             <= dp_n;
            d_minus            <= dm_n;
            tx_transfer_active <= active_n;
            tx_error           <= err_n;
        end
    end

    // Buffer handshake: get_tx_packet_data is high for exactly the cycle whose closing edge
    // latches tx_packet_data; the buffer must pop on that same edge. There is no back-pressure.
    always_comb begin
        state_n            = state;
        timer_n            = timer;
        bit_idx_n          = bit_idx;
        ones_n             = ones_cnt;
        sreg_n             = sreg;
        crc_n              = crc;
        pid_n              = pid;
        byte_cnt_n         = byte_cnt;
        dp_n               = d_plus;
        dm_n               = d_minus;
        active_n           = tx_transfer_active;
        err_n              = 1'b0;
        get_tx_packet_data = 1'b0;
        tx_en              = 1'b0;
        tx_bit             = 1'b0;
        stuff              = 1'b0;
        crc_en             = 1'b0;
        to_eop             = 1'b0;
        next_byte          = 1'b0;

        case (state)
            S_SYNC:  field_bit = SYNC_BYTE[bit_idx[2:0]];
            S_PID:   field_bit = pid[bit_idx[2:0]];
            S_DATA:  field_bit = sreg[bit_idx[2:0]];
            S_CRC:   field_bit = crc_inv[bit_idx[3:0]];
            default: field_bit = 1'b0;
        endcase

        if (state != S_IDLE) timer_n = bit_end ? '0 : timer + TW'(1);

        case (state)
            S_IDLE: begin
                if (tx_packet >= 3'd1 && tx_packet <= 3'd4) begin
                    state_n    = S_SYNC;
                    active_n   = 1'b1;
                    timer_n    = '0;
                    crc_n      = 16'hFFFF;
                    byte_cnt_n = '0;
                    case (tx_packet)
                        3'd1:    pid_n = PID_DATA0;
                        3'd2:    pid_n = 8'hD2;
                        3'd3:    pid_n = 8'h5A;
                        default: pid_n = 8'h1E;
                    endcase
                    tx_en     = 1'b1;
                    tx_bit    = SYNC_BYTE[0];
                    bit_idx_n = 5'd1;
                end else if (tx_packet >= 3'd5) begin
                    err_n = 1'b1;
                end
            end
            S_SYNC, S_PID, S_DATA, S_CRC: begin
                if (bit_end) begin
                    // A pending stuff bit always goes out before the next field bit or EOP.
                    if (ones_cnt == 3'd6) begin
                        tx_en  = 1'b1;
                        stuff  = 1'b1;
                        tx_bit = 1'b0;
                    end else if (bit_idx != field_len) begin
                        tx_en     = 1'b1;
                        tx_bit    = field_bit;
                        bit_idx_n = bit_idx + 5'd1;
                        crc_en    = (state == S_DATA);
                    end else begin
                        case (state)
                            S_SYNC: begin
                                state_n   = S_PID;
                                tx_en     = 1'b1;
                                tx_bit    = pid[0];
                                bit_idx_n = 5'd1;
                            end
                            S_PID: begin
                                if (pid == PID_DATA0) next_byte = 1'b1;
                                else                  to_eop    = 1'b1;
                            end
                            S_DATA:  next_byte = 1'b1;
                            default: to_eop    = 1'b1;
                        endcase
                    end
                end
            end
            S_EOP_SE0: begin
                if (bit_end) begin
                    if (bit_idx == 5'd1) begin
                        state_n   = S_EOP_J;
                        dp_n      = 1'b1;
                        dm_n      = 1'b0;
                        bit_idx_n = '0;
                    end else begin
                        bit_idx_n = 5'd1;
                    end
                end
            end
            S_EOP_J: begin
                if (bit_end) begin
                    state_n  = S_IDLE;
                    active_n = 1'b0;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (next_byte) begin
            if (buffer_occupancy != 7'd0 && {1'b0, byte_cnt} < MAX_B) begin
                get_tx_packet_data = 1'b1;
                sreg_n             = tx_packet_data;
                byte_cnt_n         = byte_cnt + 7'd1;
                state_n            = S_DATA;
                tx_en              = 1'b1;
                tx_bit             = tx_packet_data[0];
                crc_en             = 1'b1;
                bit_idx_n          = 5'd1;
            end else begin
                state_n   = S_CRC;
                tx_en     = 1'b1;
                tx_bit    = ~crc[0];
                bit_idx_n = 5'd1;
            end
        end

        if (to_eop) begin
            state_n   = S_EOP_SE0;
            dp_n      = 1'b0;
            dm_n      = 1'b0;
            bit_idx_n = '0;
        end

        // Reflected CRC16 (0x8005 reversed); updated only on payload bits.
        if (crc_en) crc_n = {1'b0, crc[15:1]} ^ ((crc[0] ^ tx_bit) ? 16'hA001 : 16'h0000);

        // NRZI: a 0 toggles the line, a 1 holds it.
        if (tx_en) begin
            dp_n   = tx_bit ? d_plus : ~d_plus;
            dm_n   = ~dp_n;
            ones_n = stuff ? 3'd0 : (tx_bit ? ones_cnt + 3'd1 : 3'd0);
        end
    end

endmodule

// File: tb/tb_usb_tx.sv
// tb_usb_tx: self-checking bench for usb_tx; expected line traces come from a bit-list model
// (raw field bits -> stuffing -> NRZI -> EOP) with CRC16 computed by MSB-first polynomial division.
module tb_usb_tx;

    localparam int CPB  = 8;
    localparam int MAXB = 64;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [2:0] tx_packet;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_packet_data;
    logic       get_tx_packet_data;
    logic       d_plus;
    logic       d_minus;
    logic       tx_transfer_active;
    logic       tx_error;
    logic [2:0] fsm_state;
`ifdef USB_TX_BYTE_CNT_EN
    logic [6:0] tx_byte_count;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]  buf_mem[$];
    int          buf_rd;
    logic [1:0]  exp_lines[$];
    logic [15:0] exp_q[$];

    usb_tx #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .tx_packet(tx_packet),
        .buffer_occupancy(buffer_occupancy),
        .tx_packet_data(tx_packet_data),
        .get_tx_packet_data(get_tx_packet_data),
        .d_plus(d_plus),
        .d_minus(d_minus),
        .tx_transfer_active(tx_transfer_active),
        .tx_error(tx_error),
`ifdef USB_TX_BYTE_CNT_EN
        .tx_byte_count(tx_byte_count),
`endif
        .fsm_state(fsm_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic update_buf();
        buffer_occupancy = 7'(buf_mem.size() - buf_rd);
        tx_packet_data   = (buf_rd < buf_mem.size()) ? buf_mem[buf_rd] : 8'h00;
    endtask

    task automatic load_random(input int n);
        buf_mem.delete();
        for (int i = 0; i < n; i++) buf_mem.push_back(8'($urandom_range(0, 255)));
        buf_rd = 0;
        update_buf();
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    // Reference model: expected line state per bit period, and the cycles where a pop is due.
    task automatic build_model(input logic [2:0] cmd, input int n);
        bit          raw[$];
        int          start_raw[$];
        logic [7:0]  pidb;
        logic [7:0]  sync_b;
        logic [7:0]  byte_v;
        logic [15:0] crc_m;
        logic [15:0] crc_tx;
        int          nb;
        int          run;
        int          k;
        bit          fb;
        bit          lvl;
        exp_lines.delete();
        exp_q.delete();
        sync_b = 8'h80;
        case (cmd)
            3'd1:    pidb = 8'hC3;
            3'd2:    pidb = 8'hD2;
            3'd3:    pidb = 8'h5A;
            default: pidb = 8'h1E;
        endcase
        for (int i = 0; i < 8; i++) raw.push_back(sync_b[i]);
        for (int i = 0; i < 8; i++) raw.push_back(pidb[i]);
        if (cmd == 3'd1) begin
            nb = (n < MAXB) ? n : MAXB;
            crc_m = 16'hFFFF;
            for (int j = 0; j < nb; j++) begin
                start_raw.push_back(raw.size());
                byte_v = buf_mem[j];
                for (int i = 0; i < 8; i++) begin
                    raw.push_back(byte_v[i]);
                    fb = crc_m[15] ^ byte_v[i];
                    crc_m = {crc_m[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
                end
            end
            // Remainder is bit-reversed into transmission order and complemented.
            for (int i = 0; i < 16; i++) crc_tx[i] = ~crc_m[15-i];
            for (int i = 0; i < 16; i++) raw.push_back(crc_tx[i]);
        end
        run = 0;
        k   = 0;
        lvl = 1'b1;
        for (int i = 0; i < raw.size(); i++) begin
            if (k < start_raw.size() && start_raw[k] == i) begin
                exp_q.push_back(16'(exp_lines.size() * CPB - 1));
                k++;
            end
            if (!raw[i]) lvl = ~lvl;
            exp_lines.push_back(lvl ? 2'b10 : 2'b01);
            run = raw[i] ? run + 1 : 0;
            if (run == 6) begin
                lvl = ~lvl;
                exp_lines.push_back(lvl ? 2'b10 : 2'b01);
                run = 0;
            end
        end
        exp_lines.push_back(2'b00);
        exp_lines.push_back(2'b00);
        exp_lines.push_back(2'b10);
    endtask

    // Driver + monitor for one packet. Call just after a negedge; returns after the first
    // IDLE cycle has been checked, so a following call is accepted back-to-back.
    task automatic run_packet(input logic [2:0] cmd, input int n, input int inject_cyc,
                              input logic [2:0] inject_val, output int active_cycles, output int gets);
        int         total;
        int         line_err, act_err, get_err, err_err;
        int         first_c;
        logic [1:0] first_got, first_exp, exp_l;
        bit         pop_pending;
        build_model(cmd, n);
        total = exp_lines.size() * CPB;
        line_err = 0; act_err = 0; get_err = 0; err_err = 0;
        first_c = -1; first_got = 2'b00; first_exp = 2'b00;
        pop_pending = 0; active_cycles = 0; gets = 0;
        tx_packet = cmd;
        for (int c = 0; c <= total; c++) begin
            @(negedge clk);
            if (pop_pending) begin
                buf_rd++;
                update_buf();
                pop_pending = 0;
            end
            tx_packet = (c == inject_cyc) ? inject_val : 3'd0;
            #1;
            exp_l = (c < total) ? exp_lines[c / CPB] : 2'b10;
            if ({d_plus, d_minus} !== exp_l) begin
                if (line_err == 0) begin
                    first_c = c; first_got = {d_plus, d_minus}; first_exp = exp_l;
                end
                line_err++;
            end
            if (tx_transfer_active === 1'b1) active_cycles++;
            if (tx_transfer_active !== (c < total)) act_err++;
            if (tx_error !== 1'b0) err_err++;
            if (get_tx_packet_data === 1'b1) begin
                gets++;
                pop_pending = 1;
                if (exp_q.size() > 0 && exp_q[0] == 16'(c)) void'(exp_q.pop_front());
                else get_err++;
            end
        end
        get_err += exp_q.size();
        checks++;
        if (line_err != 0) begin
            errors++;
            $display("FAIL lines cmd=%0d n=%0d: %0d cycles differ, first at cycle %0d got %b want %b",
                     cmd, n, line_err, first_c, first_got, first_exp);
        end
        checks++;
        if (act_err != 0) begin
            errors++;
            $display("FAIL active cmd=%0d n=%0d: %0d cycles wrong, active for %0d want %0d",
                     cmd, n, act_err, active_cycles, total);
        end
        checks++;
        if (get_err != 0) begin
            errors++;
            $display("FAIL get_strobe cmd=%0d n=%0d: %0d misplaced/missing pops, got %0d pops",
                     cmd, n, get_err, gets);
        end
        checks++;
        if (err_err != 0) begin
            errors++;
            $display("FAIL tx_error_quiet cmd=%0d: tx_error high %0d cycles want 0", cmd, err_err);
        end
    endtask

    task automatic test_reset();
        tx_packet = 3'd0;
        buf_mem.delete();
        buf_rd = 0;
        update_buf();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({d_plus, d_minus, tx_transfer_active, tx_error, get_tx_packet_data} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_outputs: got dp,dm,act,err,get=%b want 10000",
                     {d_plus, d_minus, tx_transfer_active, tx_error, get_tx_packet_data});
        end
        checks++;
        if (fsm_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d want 0", fsm_state);
        end
        @(negedge clk);
        n_rst = 1'b1;
        idle_cycles(2);
        checks++;
        if ({d_plus, d_minus, tx_transfer_active} !== 3'b100) begin
            errors++;
            $display("FAIL idle_after_reset: got dp,dm,act=%b want 100", {d_plus, d_minus, tx_transfer_active});
        end
    endtask

    task automatic test_ack();
        int act, gets;
        load_random(3);
        run_packet(3'd2, 3, -1, 3'd0, act, gets);
        checks++;
        if (act != 152) begin
            errors++;
            $display("FAIL ack_active_len: got %0d want 152", act);
        end
        checks++;
        if (gets != 0) begin
            errors++;
            $display("FAIL ack_no_get: got %0d want 0", gets);
        end
    endtask

    task automatic test_zero_len();
        int act, gets;
        idle_cycles(3);
        load_random(0);
        run_packet(3'd1, 0, -1, 3'd0, act, gets);
        checks++;
        if (gets != 0) begin
            errors++;
            $display("FAIL zero_len_get: got %0d want 0", gets);
        end
    endtask

    task automatic test_ff_stuff();
        int act, gets;
        idle_cycles(3);
        buf_mem.delete();
        buf_mem.push_back(8'hFF);
        buf_rd = 0;
        update_buf();
        run_packet(3'd1, 1, -1, 3'd0, act, gets);
        checks++;
        if (gets != 1) begin
            errors++;
            $display("FAIL ff_get_count: got %0d want 1", gets);
        end
    endtask

    task automatic test_illegal();
        int act, gets;
        idle_cycles(3);
        for (int v = 5; v <= 7; v++) begin
            tx_packet = 3'(v);
            @(negedge clk);
            tx_packet = 3'd0;
            #1;
            checks++;
            if ({tx_error, d_plus, d_minus, tx_transfer_active} !== 4'b1100) begin
                errors++;
                $display("FAIL illegal_pulse cmd=%0d: got err,dp,dm,act=%b want 1100", v,
                         {tx_error, d_plus, d_minus, tx_transfer_active});
            end
            @(negedge clk);
            #1;
            checks++;
            if (tx_error !== 1'b0) begin
                errors++;
                $display("FAIL illegal_one_cycle cmd=%0d: got %b want 0", v, tx_error);
            end
        end
        // Commands arriving mid-packet must be ignored (NAK, then an illegal code).
        load_random(2);
        run_packet(3'd2, 2, 40, 3'd3, act, gets);
        idle_cycles(2);
        run_packet(3'd4, 0, 100, 3'd6, act, gets);
    endtask

    task automatic test_three_bytes();
        int act, gets;
        idle_cycles(3);
        buf_mem.delete();
        buf_mem.push_back(8'h01);
        buf_mem.push_back(8'h02);
        buf_mem.push_back(8'h03);
        buf_rd = 0;
        update_buf();
        run_packet(3'd1, 3, -1, 3'd0, act, gets);
        checks++;
        if (gets != 3) begin
            errors++;
            $display("FAIL three_get_count: got %0d want 3", gets);
        end
`ifdef USB_TX_BYTE_CNT_EN
        checks++;
        if (tx_byte_count !== 7'd3) begin
            errors++;
            $display("FAIL byte_count_three: got %0d want 3", tx_byte_count);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int act, gets;
        idle_cycles(3);
        load_random(2);
        run_packet(3'd1, 2, -1, 3'd0, act, gets);
        load_random(0);
        run_packet(3'd3, 0, -1, 3'd0, act, gets);
        load_random(1);
        run_packet(3'd1, 1, -1, 3'd0, act, gets);
    endtask

    task automatic test_max_bytes();
        int act, gets;
        idle_cycles(3);
        load_random(MAXB + 2);
        run_packet(3'd1, MAXB + 2, -1, 3'd0, act, gets);
        checks++;
        if (gets != MAXB) begin
            errors++;
            $display("FAIL max_get_count: got %0d want %0d", gets, MAXB);
        end
`ifdef USB_TX_BYTE_CNT_EN
        checks++;
        if (tx_byte_count !== 7'(MAXB)) begin
            errors++;
            $display("FAIL byte_count_max: got %0d want %0d", tx_byte_count, MAXB);
        end
`endif
    endtask

    task automatic test_random();
        int act, gets, n;
        logic [2:0] cmd;
        for (int k = 0; k < 8; k++) begin
            idle_cycles($urandom_range(0, 3));
            cmd = 3'($urandom_range(1, 4));
            n = $urandom_range(0, 6);
            load_random(n);
            run_packet(cmd, n, -1, 3'd0, act, gets);
        end
    endtask

    task automatic test_reset_mid_packet();
        int act, gets;
        idle_cycles(3);
        load_random(4);
        tx_packet = 3'd1;
        @(negedge clk);
        tx_packet = 3'd0;
        repeat (190) @(negedge clk);
        #1;
        checks++;
        if (tx_transfer_active !== 1'b1) begin
            errors++;
            $display("FAIL mid_packet_active: got %b want 1", tx_transfer_active);
        end
        #1;
        n_rst = 1'b0;
        #1;
        checks++;
        if ({d_plus, d_minus, tx_transfer_active, tx_error, get_tx_packet_data} !== 5'b10000) begin
            errors++;
            $display("FAIL async_reset_outputs: got dp,dm,act,err,get=%b want 10000",
                     {d_plus, d_minus, tx_transfer_active, tx_error, get_tx_packet_data});
        end
`ifdef USB_TX_BYTE_CNT_EN
        checks++;
        if (tx_byte_count !== 7'd0) begin
            errors++;
            $display("FAIL async_reset_count: got %0d want 0", tx_byte_count);
        end
`endif
        @(negedge clk);
        n_rst = 1'b1;
        idle_cycles(2);
        load_random(0);
        run_packet(3'd3, 0, -1, 3'd0, act, gets);
    endtask

    initial begin
        test_reset();
        test_ack();
        test_zero_len();
        test_ff_stuff();
        test_illegal();
        test_three_bytes();
        test_back_to_back();
        test_max_bytes();
        test_random();
        test_reset_mid_packet();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
